regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the write side of a bank of NUM_REGS 16-bit registers (each clk/ce/data_in/data_out, capture when ce=1) between two requesters, port A (ALU writeback) and port B (load unit).
- Arbitrates with round-robin priority, stages the winning write, and drives one-hot per-register ce plus a shared data bus one cycle later.
- Acknowledges each requester, flags out-of-range addresses, and keeps a saturating count of committed writes.

Parameters:
- DATA_W, 16, width of register data.
- NUM_REGS, 8, number of registers in the bank (2..16).
- ADDR_W, 4, requester address width; must satisfy 2**ADDR_W >= NUM_REGS.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_a  input  1  port A write request; held until ack_a.
- addr_a  input  ADDR_W  port A target register index.
- data_a  input  DATA_W  port A write data.
- req_b  input  1  port B write request; held until ack_b.
- addr_b  input  ADDR_W  port B target register index.
- data_b  input  DATA_W  port B write data.
- ack_a  output  1  one-cycle pulse: port A request consumed.
- ack_b  output  1  one-cycle pulse: port B request consumed.
- err_a  output  1  valid with ack_a: address >= NUM_REGS, no write done.
- err_b  output  1  valid with ack_b: address >= NUM_REGS, no write done.
- reg_ce  output  NUM_REGS  one-hot (or zero) clock enable to register bank.
- reg_data  output  DATA_W  data to all register data_in.
- wr_count  output  16  committed writes, saturating at 16'hFFFF.

Behaviour:
- Reset (rst_n=0, async):
  - All outputs go to 0 and the staging stage is cleared.
  - Priority pointer is set to A.
  - A grant in flight at reset is discarded: no ce is issued and no ack follows.
- Effective request:
  - eff_a = req_a & ~ack_a; eff_b = req_b & ~ack_b.
  - A requester is masked in the cycle its ack is high. This prevents double-granting a held request.
- Arbitration, cycle N (combinational on eff_*):
  - Only one effective request: it wins.
  - Both effective: the pointer holder wins.
  - On any grant, the pointer moves to the loser's side. If only one requested, the pointer moves to the other side.
- Staging, edge ending cycle N:
  - Winner's addr/data and an in-range flag are registered.
  - The winner's ack and err are registered.
  - Cycle N+1 therefore shows ack_x=1 and err_x=(addr >= NUM_REGS).
- Commit, cycle N+1:
  - In range: reg_ce has only bit[addr] set and reg_data = staged data. The bank captures at the edge ending N+1.
  - Out of range: reg_ce=0 and reg_data is unchanged.
  - Latency from request asserted to data visible at register data_out: 2 edges.
- Without a grant, reg_ce=0 and ack_*/err_*=0 the next cycle. reg_data holds its last value.
- Throughput:
  - One write per cycle is sustained when A and B alternate.
  - One requester held continuously gets a grant every other cycle, because of masking.
- Same address from A then B back-to-back: both commit in grant order and the later value remains.
- wr_count:
  - Increments on every cycle with reg_ce != 0.
  - Holds at 16'hFFFF and does not wrap.
  - Out-of-range acks do not count.
- Requester data/addr are sampled only in the grant cycle; later changes do not affect the staged write.
- No state machine beyond the 1-bit pointer and the 1-deep stage; there is no backpressure from the bank.

Decomposition:
- Shared package/include: DATA_W, NUM_REGS, ADDR_W defaults, and requester index constants (REQ_A=0, REQ_B=1).
- Sub-module rr_arbiter_2:
  - Inputs: clk, rst_n, two effective requests.
  - Outputs: one-hot grant and the pointer register.
  - The top level holds the staging, decode, ack/err and counter logic.

Test Plan:
- Reset: assert rst_n=0 mid-grant (req_a=1, addr_a=2) -> reg_ce=0, ack_a=0, wr_count=0 immediately. After release with req_a still high, the grant is reissued.
- Single write: req_a=1, addr_a=3, data_a=16'hBEEF at cycle N -> ack_a=1, err_a=0, reg_ce=8'b0000_1000, reg_data=16'hBEEF at N+1. Register 3 reads 16'hBEEF after that edge; wr_count=1.
- Contention: req_a and req_b both asserted (addr 1 / 16'h1111, addr 1 / 16'h2222) after reset -> A granted first (ack_a at N+1), B at N+2. Register 1 ends at 16'h2222; wr_count=2.
- Fairness: both requesters held for 6 cycles, each re-asserted after its ack -> grants strictly alternate, with no requester granted twice in a row.
- Out of range: req_b=1, addr_b=9 -> ack_b=1, err_b=1, reg_ce=0, wr_count unchanged.
- Saturation: force 65536+ committed writes (or preload the counter in the bench) -> wr_count stays at 16'hFFFF.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter.
// Requester indices select bits of the request/grant vectors.
package regfile_write_arbiter_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int NUM_REGS_DEF = 8;
    localparam int ADDR_W_DEF   = 4;
    localparam int CNT_W        = 16;

    localparam int REQ_A = 0;
    localparam int REQ_B = 1;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter with a 1-bit priority pointer.
// Pointer 0 favours A; after any grant it points at the other side.
module rr_arbiter_2
    import regfile_write_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       ptr_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        if (req_i[REQ_A] && (!req_i[REQ_B] || ptr_q == 1'(REQ_A))) begin
            gnt_o[REQ_A] = 1'b1;
            ptr_d        = 1'(REQ_B);
        end else if (req_i[REQ_B]) begin
            gnt_o[REQ_B] = 1'b1;
            ptr_d        = 1'(REQ_A);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'(REQ_A);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates two write requesters onto one register bank write port.
// The winning write is staged one cycle, then drives one-hot ce and data.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_a,
    input  logic [ADDR_W-1:0]   addr_a,
    input  logic [DATA_W-1:0]   data_a,
    input  logic                req_b,
    input  logic [ADDR_W-1:0]   addr_b,
    input  logic [DATA_W-1:0]   data_b,
    output logic                ack_a,
    output logic                ack_b,
    output logic                err_a,
    output logic                err_b,
    output logic [NUM_REGS-1:0] reg_ce,
    output logic [DATA_W-1:0]   reg_data,
    output logic [CNT_W-1:0]    wr_count
);

    localparam logic [ADDR_W:0]   NREGS  = (ADDR_W+1)'(NUM_REGS);
    localparam logic [NUM_REGS-1:0] CE_ONE = NUM_REGS'(1);

    logic [1:0]          eff;
    logic [1:0]          gnt;
    logic                unused_ptr;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic                in_rng;
    logic                commit;

    logic                ack_a_q, ack_a_d;
    logic                ack_b_q, ack_b_d;
    logic                err_a_q, err_a_d;
    logic                err_b_q, err_b_d;
    logic [NUM_REGS-1:0] ce_q, ce_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // A request is hidden in its ack cycle so a held request is not granted twice.
    assign eff[REQ_A] = req_a & ~ack_a_q;
    assign eff[REQ_B] = req_b & ~ack_b_q;

    rr_arbiter_2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (eff),
        .gnt_o (gnt),
        .ptr_o (unused_ptr)
    );

    always_comb begin
        win_addr = gnt[REQ_B] ? addr_b : addr_a;
        win_data = gnt[REQ_B] ? data_b : data_a;
        in_rng   = {1'b0, win_addr} < NREGS;
        commit   = (|gnt) && in_rng;

        ack_a_d  = gnt[REQ_A];
        ack_b_d  = gnt[REQ_B];
        err_a_d  = gnt[REQ_A] && !in_rng;
        err_b_d  = gnt[REQ_B] && !in_rng;
        ce_d     = commit ? (CE_ONE << win_addr) : '0;
        data_d   = commit ? win_data : data_q;

        cnt_d    = cnt_q;
        if ((|ce_q) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            err_a_q <= 1'b0;
            err_b_q <= 1'b0;
            ce_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            ack_a_q <= ack_a_d;
            ack_b_q <= ack_b_d;
            err_a_q <= err_a_d;
            err_b_q <= err_b_d;
            ce_q    <= ce_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ack_a    = ack_a_q;
    assign ack_b    = ack_b_q;
    assign err_a    = err_a_q;
    assign err_b    = err_b_q;
    assign reg_ce   = ce_q;
    assign reg_data = data_q;
    assign wr_count = cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed table, reset/fairness/saturation sequences
// and randomized traffic against a behavioural model of the arbiter.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic [3:0]  addr_a = '0, addr_b = '0;
    logic [15:0] data_a = '0, data_b = '0;
    logic        ack_a, ack_b, err_a, err_b;
    logic [7:0]  reg_ce;
    logic [15:0] reg_data, wr_count;

    int passed = 0;
    int total  = 0;

    logic [15:0] bank [8];

    regfile_write_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_a    (req_a),
        .addr_a   (addr_a),
        .data_a   (data_a),
        .req_b    (req_b),
        .addr_b   (addr_b),
        .data_b   (data_b),
        .ack_a    (ack_a),
        .ack_b    (ack_b),
        .err_a    (err_a),
        .err_b    (err_b),
        .reg_ce   (reg_ce),
        .reg_data (reg_data),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (reg_ce[i]) bank[i] <= reg_data;
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h", nm, got, exp);
    endtask

    // Behavioural model: who was granted last, and what the bank should hold.
    bit          m_ack_a, m_ack_b, m_err_a, m_err_b;
    logic [7:0]  m_ce;
    logic [15:0] m_data;
    int          m_cnt;
    bit          last_b;
    logic [15:0] mem [8];

    task automatic model_reset();
        m_ack_a = 0; m_ack_b = 0; m_err_a = 0; m_err_b = 0;
        m_ce = '0; m_data = '0; m_cnt = 0; last_b = 1;
    endtask

    task automatic model_step();
        bit ea, eb, wa, wb, ok;
        int wad;
        ea = req_a && !m_ack_a;
        eb = req_b && !m_ack_b;
        wa = ea && (!eb || last_b);
        wb = eb && !wa;
        if (m_ce != 0) begin
            for (int i = 0; i < 8; i++) if (m_ce[i]) mem[i] = m_data;
            if (m_cnt < 65535) m_cnt++;
        end
        wad = wa ? int'(addr_a) : int'(addr_b);
        ok  = wad < 8;
        m_ack_a = wa;
        m_ack_b = wb;
        m_err_a = wa && !ok;
        m_err_b = wb && !ok;
        if ((wa || wb) && ok) begin
            m_ce   = 8'(1 << wad);
            m_data = wa ? data_a : data_b;
        end else begin
            m_ce = '0;
        end
        if (wa) last_b = 0;
        if (wb) last_b = 1;
    endtask

    task automatic rst_dut();
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [63:0] outs();
        return {20'b0, ack_a, ack_b, err_a, err_b, reg_ce, reg_data, wr_count};
    endfunction

    function automatic logic [63:0] mouts();
        return {20'b0, m_ack_a, m_ack_b, m_err_a, m_err_b, m_ce, m_data, 16'(m_cnt)};
    endfunction

    typedef struct {
        logic        ra;
        logic [3:0]  aa;
        logic [15:0] da;
        logic        rb;
        logic [3:0]  ab;
        logic [15:0] db;
        logic [3:0]  flg;
        logic [7:0]  ce;
        logic [15:0] d;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [9];

    initial begin
        for (int i = 0; i < 8; i++) begin
            bank[i] = '0;
            mem[i]  = '0;
        end
        //        ra aa  da        rb ab  db        ack/err  ce     data      cnt
        tbl[0] = '{1, 1, 16'h1111, 1, 1, 16'h2222, 4'b1000, 8'h02, 16'h1111, 16'd0};
        tbl[1] = '{0, 0, 16'h0000, 1, 1, 16'h2222, 4'b0100, 8'h02, 16'h2222, 16'd1};
        tbl[2] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 4'b0000, 8'h00, 16'h2222, 16'd2};
        tbl[3] = '{1, 3, 16'hBEEF, 0, 0, 16'h0000, 4'b1000, 8'h08, 16'hBEEF, 16'd2};
        tbl[4] = '{0, 0, 16'h0000, 1, 9, 16'h9999, 4'b0101, 8'h00, 16'hBEEF, 16'd3};
        tbl[5] = '{1,15, 16'h5555, 0, 0, 16'h0000, 4'b1010, 8'h00, 16'hBEEF, 16'd3};
        tbl[6] = '{0, 0, 16'h0000, 1, 7, 16'h7777, 4'b0100, 8'h80, 16'h7777, 16'd3};
        tbl[7] = '{1, 0, 16'h0001, 0, 0, 16'h0000, 4'b1000, 8'h01, 16'h0001, 16'd4};
        tbl[8] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 4'b0000, 8'h00, 16'h0001, 16'd5};

        // Reset in the middle of a grant, then reissue.
        rst_dut();
        req_a = 1'b1; addr_a = 4'd2; data_a = 16'h1234;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {ack_a, reg_ce, wr_count}, '0);
        @(posedge clk); #1;
        chk("rst_no_ack", {ack_a, reg_ce}, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_regrant", {ack_a, err_a, reg_ce, reg_data}, {1'b1, 1'b0, 8'h04, 16'h1234});
        req_a = 1'b0;
        @(posedge clk); #1;
        chk("rst_bank2", bank[2], 16'h1234);
        chk("rst_cnt", wr_count, 16'd1);

        // Randomized traffic against the model.
        rst_dut();
        mem[2] = 16'h1234;
        for (int c = 0; c < 3000; c++) begin
            chk("rand", outs(), mouts());
            if (!req_a || m_ack_a) begin
                req_a  = ($urandom_range(0, 3) != 0);
                addr_a = 4'($urandom_range(0, 11));
                data_a = 16'($urandom);
            end
            if (!req_b || m_ack_b) begin
                req_b  = ($urandom_range(0, 3) != 0);
                addr_b = 4'($urandom_range(0, 11));
                data_b = 16'($urandom);
            end
            model_step();
            @(posedge clk); #1;
        end
        req_a = 1'b0;
        req_b = 1'b0;
        for (int c = 0; c < 2; c++) begin
            model_step();
            @(posedge clk); #1;
            chk("rand_drain", outs(), mouts());
        end
        for (int i = 0; i < 8; i++) chk("rand_bank", bank[i], mem[i]);

        // Directed table from reset.
        rst_dut();
        for (int i = 0; i < 9; i++) begin
            req_a = tbl[i].ra; addr_a = tbl[i].aa; data_a = tbl[i].da;
            req_b = tbl[i].rb; addr_b = tbl[i].ab; data_b = tbl[i].db;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d", i), {ack_a, ack_b, err_a, err_b, reg_ce, reg_data, wr_count},
                {tbl[i].flg, tbl[i].ce, tbl[i].d, tbl[i].cnt});
        end
        chk("tbl_reg1", bank[1], 16'h2222);
        chk("tbl_reg3", bank[3], 16'hBEEF);
        chk("tbl_reg7", bank[7], 16'h7777);
        chk("tbl_reg0", bank[0], 16'h0001);

        // Fairness: both held, grants must alternate starting with A.
        rst_dut();
        req_a = 1'b1; addr_a = 4'd4; data_a = 16'hAAAA;
        req_b = 1'b1; addr_b = 4'd5; data_b = 16'hBBBB;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk($sformatf("fair%0d", i), {ack_a, ack_b}, (i % 2 == 0) ? 2'b10 : 2'b01);
        end

        // Saturation: one commit per cycle while both stay held.
        for (int i = 0; i < 65540; i++) @(posedge clk);
        #1;
        chk("sat", wr_count, 16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_hold", wr_count, 16'hFFFF);
        chk("sat_bank", {bank[4], bank[5]}, {16'hAAAA, 16'hBBBB});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
